// File: rtl/mdu_sequencer.sv
// RV32M multiply/divide sequencer: one shift-add / restoring-divide engine shared by
// all eight funct3 ops, with the RISC-V divide-by-zero and signed-overflow results.
module mdu_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            kill_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PREP  = 3'd1;
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_FIXUP = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              is_div_s;
  logic              sgn_a_s, sgn_b_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s;
  logic              div_zero_s, div_ovf_s;
  logic [XLEN-1:0]   special_res_s;
  logic [XLEN:0]     mul_sum_s;
  logic [XLEN:0]     rem_sh_s;
  logic [XLEN:0]     div_diff_s;
  logic [2*XLEN-1:0] mul_step_s, div_step_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res_s;

  // Datapath: operand signs/magnitudes, one iteration step, and final sign fixup.
  always_comb begin
    is_div_s = funct3_q[2];
    sgn_a_s  = 1'b0;
    sgn_b_s  = 1'b0;
    case (funct3_q)
      3'b001:         begin sgn_a_s = a_q[XLEN-1]; sgn_b_s = b_q[XLEN-1]; end
      3'b010:         begin sgn_a_s = a_q[XLEN-1]; sgn_b_s = 1'b0;        end
      3'b100, 3'b110: begin sgn_a_s = a_q[XLEN-1]; sgn_b_s = b_q[XLEN-1]; end
      default:        begin sgn_a_s = 1'b0;        sgn_b_s = 1'b0;        end
    endcase
    mag_a_s = sgn_a_s ? (-a_q) : a_q;
    mag_b_s = sgn_b_s ? (-b_q) : b_q;

    div_zero_s = is_div_s & (b_q == '0);
    div_ovf_s  = is_div_s & ~funct3_q[0] & (a_q == INT_MIN) & (b_q == '1);
    if (div_zero_s) begin
      special_res_s = funct3_q[1] ? a_q : '1;
    end else if (div_ovf_s) begin
      special_res_s = funct3_q[1] ? '0 : INT_MIN;
    end else begin
      special_res_s = '0;
    end

    // Multiply: conditionally add multiplicand into the high half, then shift right.
    mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_step_s = {mul_sum_s, acc_q[XLEN-1:1]};

    // Divide: {remainder, dividend/quotient} shifts left; the top bit of the trial difference is the borrow.
    rem_sh_s   = acc_q[2*XLEN-1:XLEN-1];
    div_diff_s = rem_sh_s - {1'b0, b_q};
    if (div_diff_s[XLEN]) begin
      div_step_s = {rem_sh_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_step_s = {div_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    prod_s = (sign_a_q ^ sign_b_q) ? (-acc_q) : acc_q;
    quo_s  = (sign_a_q ^ sign_b_q) ? (-acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_s  = sign_a_q ? (-acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
    case (funct3_q)
      3'b000:                 fix_res_s = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res_s = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res_s = quo_s;
      3'b110, 3'b111:         fix_res_s = rem_s;
      default:                fix_res_s = prod_s[XLEN-1:0];
    endcase
  end

  // Sequencer next-state logic; kill aborts everything except the DONE pulse.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (kill_i) begin
          state_d = S_IDLE;
        end else if (start_i) begin
          funct3_d = funct3_i;
          a_d      = rs1_i;
          b_d      = rs2_i;
          state_d  = S_PREP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        if (kill_i) begin
          state_d = S_IDLE;
        end else if (div_zero_s || div_ovf_s) begin
          result_d = special_res_s;
          state_d  = S_DONE;
        end else begin
          sign_a_d = sgn_a_s;
          sign_b_d = sgn_b_s;
          a_d      = mag_a_s;
          b_d      = mag_b_s;
          acc_d    = is_div_s ? {{XLEN{1'b0}}, mag_a_s} : {{XLEN{1'b0}}, mag_b_s};
          cnt_d    = CNT_LOAD;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        if (kill_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div_s ? div_step_s : mul_step_s;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = S_FIXUP;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_FIXUP: begin
        if (kill_i) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_res_s;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      funct3_q <= 3'b000;
      a_q      <= '0;
      b_q      <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ready_o  = ready_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: directed RV32M cases, kill/reset scenarios and random ops
// checked against a plain-arithmetic reference model.
module tb_mdu_sequencer;

  localparam logic [31:0] MIN32  = 32'h8000_0000;
  localparam logic [31:0] ONES32 = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        kill_i;
  logic        ready_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_res = 32'h0;

  mdu_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .kill_i   (kill_i),
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ps;
    logic [63:0] w;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      3'd0: begin w = {32'h0, a} * {32'h0, b}; return w[31:0]; end
      3'd1: begin ps = sa * sb; w = ps; return w[63:32]; end
      3'd2: begin ps = sa * longint'({32'h0, b}); w = ps; return w[63:32]; end
      3'd3: begin w = {32'h0, a} * {32'h0, b}; return w[63:32]; end
      3'd4: begin
        if (b == 32'h0) return ONES32;
        if (a == MIN32 && b == ONES32) return MIN32;
        ps = sa / sb; w = ps; return w[31:0];
      end
      3'd5: begin
        if (b == 32'h0) return ONES32;
        return a / b;
      end
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == MIN32 && b == ONES32) return 32'h0;
        ps = sa % sb; w = ps; return w[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'h0 || (!f[0] && a == MIN32 && b == ONES32))) return 2;
    return 35;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return ONES32;
      3: return MIN32;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_ready();
    int k;
    k = 0;
    while (ready_o !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Issue one op and check latency, busy, single done pulse and result; hold keeps start high and scrambles inputs.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit hold, input string tag);
    int          n, pulses, exp_lat;
    bit          busy_ok;
    logic [31:0] exp_r;
    exp_r   = ref_result(f, a, b);
    exp_lat = ref_latency(f, a, b);
    wait_ready();
    @(negedge clk);
    chk({tag, ".ready"}, 32'(ready_o), 32'd1);
    start_i  = 1'b1;
    funct3_i = f;
    rs1_i    = a;
    rs2_i    = b;
    @(posedge clk);
    n = 0; pulses = 0; busy_ok = 1'b1;
    while (pulses == 0 && n < 60) begin
      @(negedge clk);
      n++;
      if (hold) begin
        rs1_i    = $urandom;
        rs2_i    = $urandom;
        funct3_i = 3'($urandom_range(0, 7));
      end else begin
        start_i = 1'b0;
      end
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      if (done_o === 1'b1) pulses++;
    end
    start_i = 1'b0;
    chk({tag, ".lat"}, 32'(n), 32'(exp_lat));
    chk({tag, ".res"}, result_o, exp_r);
    chk({tag, ".busy"}, 32'(busy_ok), 32'd1);
    last_res = exp_r;
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(done_o), 32'd0);
    chk({tag, ".idle_ready"}, 32'(ready_o), 32'd1);
    chk({tag, ".res_hold"}, result_o, exp_r);
    if (hold) begin
      @(negedge clk);
      chk({tag, ".not_queued"}, 32'(busy_o), 32'd0);
    end
  endtask

  task automatic count_quiet(input string tag);
    int pulses;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o === 1'b1) pulses++;
    end
    chk({tag, ".no_done"}, 32'(pulses), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; kill_i = 1'b0;
    funct3_i = 3'd0; rs1_i = 32'h0; rs2_i = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst.ready", 32'(ready_o), 32'd1);
    chk("rst.busy", 32'(busy_o), 32'd0);
    chk("rst.done", 32'(done_o), 32'd0);
    chk("rst.result", result_o, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst.ready", 32'(ready_o), 32'd1);

    // Kill wins over start in IDLE.
    start_i = 1'b1; kill_i = 1'b1; funct3_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd5;
    @(negedge clk);
    start_i = 1'b0; kill_i = 1'b0;
    chk("kill_idle.ready", 32'(ready_o), 32'd1);
    chk("kill_idle.busy", 32'(busy_o), 32'd0);

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, "mul");
    do_op(3'd1, MIN32, MIN32, 1'b0, "mulh");
    do_op(3'd3, ONES32, ONES32, 1'b0, "mulhu");
    do_op(3'd2, ONES32, ONES32, 1'b0, "mulhsu");
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, "div");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, "rem");
    do_op(3'd5, 32'd100, 32'd7, 1'b0, "divu");
    do_op(3'd7, 32'd100, 32'd7, 1'b0, "remu");
    do_op(3'd4, 32'd1234, 32'd0, 1'b0, "div_by0");
    do_op(3'd7, 32'd1234, 32'd0, 1'b0, "remu_by0");
    do_op(3'd4, MIN32, ONES32, 1'b0, "div_ovf");
    do_op(3'd6, MIN32, ONES32, 1'b0, "rem_ovf");
    do_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, "mulh_hold");

    // Kill ten cycles into a DIV.
    wait_ready();
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'd4; rs1_i = 32'd1000; rs2_i = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    chk("kill.ready", 32'(ready_o), 32'd1);
    chk("kill.busy", 32'(busy_o), 32'd0);
    chk("kill.done", 32'(done_o), 32'd0);
    chk("kill.result", result_o, last_res);
    count_quiet("kill");
    do_op(3'd0, 32'd3, 32'd5, 1'b0, "mul_after_kill");

    for (int i = 0; i < 24; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      do_op(f, a, b, 1'b0, $sformatf("rnd%0d_f%0d", i, f));
    end

    // Asynchronous reset in the middle of CALC.
    wait_ready();
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'd5; rs1_i = 32'd99999; rs2_i = 32'd13;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.ready", 32'(ready_o), 32'd1);
    chk("arst.busy", 32'(busy_o), 32'd0);
    chk("arst.done", 32'(done_o), 32'd0);
    chk("arst.result", result_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    count_quiet("arst");
    do_op(3'd7, 32'd99999, 32'd13, 1'b0, "remu_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle controller and iterative datapath for the RV32M multiply/divide instructions.
- Sits beside the core ALU. The decode stage issues an M-extension op with both operands, and the block stalls the pipeline via busy_o until the result is ready.
- One shift-add/shift-subtract engine is shared by all eight funct3 ops, and this block sequences it.
- Implements the RISC-V corner-case rules for division by zero and signed overflow.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  issue request; sampled only while ready_o=1.
- funct3_i  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_i  input  XLEN  operand A (multiplicand / dividend).
- rs2_i  input  XLEN  operand B (multiplier / divisor).
- kill_i  input  1  abort an in-flight op (pipeline flush).
- ready_o  output  1  high in IDLE only.
- busy_o  output  1  stall to core; high from the cycle after acceptance up to and including the DONE cycle.
- done_o  output  1  single-cycle pulse; result_o is valid in this cycle.
- result_o  output  XLEN  final result; holds its value until the next done_o.

Behaviour:
- Reset values: FSM=IDLE, ready_o=1, busy_o=0, done_o=0, result_o=0, counter=0, internal accumulators=0.
- FSM states: IDLE, PREP, CALC, FIXUP, DONE.
- IDLE: when start_i=1, latch funct3, rs1 and rs2, then go to PREP. When start_i=0, stay in IDLE.
- PREP (1 cycle):
  - Record operand signs per op. MULH: both signed. MULHSU: A signed, B unsigned. DIV/REM: both signed. All others: unsigned.
  - Convert signed operands to magnitudes and load the counter with XLEN.
  - Special cases go to DONE directly and skip CALC and FIXUP:
    - Divide by zero (rs2=0): DIV/DIVU give all ones; REM/REMU give rs1.
    - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - Otherwise go to CALC.
- CALC (exactly XLEN cycles, one bit per cycle, counter decrements):
  - Multiply: 2*XLEN-bit product register, add-shift on the multiplier LSB.
  - Divide: restoring, shift the remainder left, trial subtract, set the quotient bit.
  - When the counter reaches 0, go to FIXUP.
- FIXUP (1 cycle):
  - Product sign = signA XOR signB; negate the full 2*XLEN product if it is negative.
  - Quotient sign = signA XOR signB; remainder sign = signA.
  - Result selection: MUL takes the low XLEN bits; MULH/MULHSU/MULHU take the high XLEN bits; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Go to DONE.
- DONE (1 cycle): drive done_o=1 with result_o valid, then return to IDLE.
- Latency:
  - Normal op: acceptance at edge T; done_o asserted in cycle T+XLEN+3 (PREP + 32 CALC + FIXUP + DONE = 35 cycles busy).
  - Special-case op: done_o asserted in the second cycle after acceptance.
- Back-to-back ops: a new start_i is accepted only in IDLE, so the minimum issue interval is latency+1. start_i outside IDLE is ignored and never queued.
- kill_i:
  - In PREP, CALC or FIXUP: return to IDLE next cycle with no done_o pulse; result_o keeps its previous value.
  - In DONE: ignored; the pulse completes.
  - In IDLE: it has priority over start_i in the same cycle, so the start is not accepted.
- Async reset mid-operation: immediately forces the reset values; the op is lost with no done_o.
- Arithmetic: all internal sums use XLEN+1 bits to capture borrow; no arithmetic exceptions are raised.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB; done_o exactly 35 cycles after acceptance; busy_o high throughout.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Divide by zero:
  - DIV 1234/0 -> 0xFFFFFFFF.
  - REMU 1234/0 -> 1234.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
  - In each case done_o asserts 2 cycles after acceptance.
- kill_i asserted 10 cycles into a DIV -> no done_o, ready_o=1 on the next cycle, result_o unchanged; a following MUL 3×5 -> 15.
- rst_n pulled low mid-CALC -> all outputs return to reset values asynchronously. start_i held high during busy -> ignored; the op issues only once ready_o returns.
